// File: rtl/lcd_pkg.sv
// Shared LCD definitions: line geometry, blank line and scheduler state encoding.
package lcd_pkg;

  localparam int unsigned LCD_CHARS  = 20;
  localparam int unsigned LCD_LINE_W = 160;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // A full line of ASCII spaces.
  localparam logic [LCD_LINE_W-1:0] BLANK_LINE = {LCD_CHARS{ASCII_SPACE}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SAVE,
    HOLD
  } lcd_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod N) for the first
// active request and returns its one-hot grant and encoded index.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

  // Walk candidates ptr+1 .. ptr+N; the first active one wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned cand;
      cand = (32'(ptr) + k) % N;
      if (!valid && req[SEL_W'(cand)]) begin
        valid              = 1'b1;
        gnt[SEL_W'(cand)]  = 1'b1;
        idx                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lcd_line_scheduler.sv
// Round-robin scheduler sharing the LCD line latch between N_REQ requesters.
// Grants one requester, registers its line, strobes save, then holds off
// further updates for HOLD_CYCLES so the display sequencer can refresh.
module lcd_line_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 2_000_000
) (
  input  logic                        ckht,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*LCD_LINE_W-1:0] req_text,
  output logic [N_REQ-1:0]            ack,
  output logic [LCD_LINE_W-1:0]       lcd_data,
  output logic                        save,
  output logic                        busy,
  output logic [2:0]                  last_grant
);

  // A zero hold interval still needs a 1-bit counter to keep the netlist legal.
  localparam int unsigned CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  lcd_sched_state_t        state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [2:0]              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [LCD_LINE_W-1:0]   lcd_data_q, lcd_data_d;

  logic [N_REQ-1:0]        arb_gnt;
  logic [2:0]              arb_idx;
  logic                    arb_valid;
  logic [LCD_LINE_W-1:0]   text_sel;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (3)
  ) u_arb (
    .req   (req),
    .ptr   (last_grant_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Select the granted requester's line; last_grant_q holds the winner index.
  always_comb begin
    text_sel = BLANK_LINE;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (last_grant_q == 3'(i)) begin
        text_sel = req_text[LCD_LINE_W*i +: LCD_LINE_W];
      end
    end
  end

  // Next-state logic for the FSM, grant capture, hold counter and line register.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    lcd_data_d   = lcd_data_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d      = LOAD;
          gnt_d        = arb_gnt;
          last_grant_d = arb_idx;
        end
      end
      LOAD: begin
        state_d    = SAVE;
        lcd_data_d = text_sel;
      end
      SAVE: begin
        if (HOLD_CYCLES > 0) begin
          state_d    = HOLD;
          hold_cnt_d = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_grant_q <= 3'(N_REQ - 1);
      hold_cnt_q   <= '0;
      lcd_data_q   <= BLANK_LINE;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      lcd_data_q   <= lcd_data_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them at once.
  always_comb begin
    ack        = (state_q == LOAD) ? gnt_q : '0;
    save       = (state_q == SAVE);
    busy       = (state_q != IDLE);
    lcd_data   = lcd_data_q;
    last_grant = last_grant_q;
  end

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Directed bench for lcd_line_scheduler with HOLD_CYCLES=5, plus a
// HOLD_CYCLES=0 instance for back-to-back update spacing.
module tb_lcd_line_scheduler;

  logic         ckht;
  logic         rst;
  logic [3:0]   req;
  logic [639:0] req_text;
  logic [3:0]   ack;
  logic [159:0] lcd_data;
  logic         save;
  logic         busy;
  logic [2:0]   last_grant;

  logic         rst_z;
  logic [3:0]   req_z;
  logic [3:0]   ack_z;
  logic [159:0] lcd_data_z;
  logic         save_z;
  logic         busy_z;
  logic [2:0]   last_grant_z;

  logic [159:0] texts [4];
  logic [159:0] blank;

  int n_checks;
  int n_errors;

  lcd_line_scheduler #(
    .N_REQ       (4),
    .HOLD_CYCLES (5)
  ) dut (
    .ckht       (ckht),
    .rst        (rst),
    .req        (req),
    .req_text   (req_text),
    .ack        (ack),
    .lcd_data   (lcd_data),
    .save       (save),
    .busy       (busy),
    .last_grant (last_grant)
  );

  lcd_line_scheduler #(
    .N_REQ       (4),
    .HOLD_CYCLES (0)
  ) dut_z (
    .ckht       (ckht),
    .rst        (rst_z),
    .req        (req_z),
    .req_text   (req_text),
    .ack        (ack_z),
    .lcd_data   (lcd_data_z),
    .save       (save_z),
    .busy       (busy_z),
    .last_grant (last_grant_z)
  );

  initial ckht = 1'b0;
  always #5 ckht = ~ckht;

  assign req_text = {texts[3], texts[2], texts[1], texts[0]};

  function automatic logic [159:0] pad_line(input string s);
    logic [159:0] line;
    for (int i = 0; i < 20; i++) begin
      line[159-8*i -: 8] = (i < s.len()) ? 8'(s[i]) : 8'h20;
    end
    return line;
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ckht);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, 160'(busy), 160'(0));
  endtask

  task automatic count_saves(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (save) cnt++;
    end
    check(tag, 160'(cnt), 160'(0));
  endtask

  initial begin
    logic [2:0] grants [8];
    int         save_cyc [8];
    int         ng;
    int         ns;
    int         cyc;

    n_checks = 0;
    n_errors = 0;
    texts[0] = pad_line("MENU: SETTINGS");
    texts[1] = pad_line("HUMIDITY 40%");
    texts[2] = pad_line("TEMP 25C");
    texts[3] = pad_line("STATUS OK");
    blank    = {20{8'h20}};
    rst   = 1'b1;
    rst_z = 1'b1;
    req   = '0;
    req_z = '0;

    // Reset release, no requests.
    tick();
    tick();
    rst = 1'b0;
    check("rst_lcd_data", lcd_data, blank);
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_ack", 160'(ack), 160'(0));
    check("rst_last_grant", 160'(last_grant), 160'(3));
    count_saves("rst_no_save", 50);
    check("rst_lcd_data_after", lcd_data, blank);

    // Single request from requester 2.
    req = 4'b0100;
    tick();
    check("single_ack", 160'(ack), 160'(4'b0100));
    check("single_busy_c1", 160'(busy), 160'(1));
    check("single_last_grant", 160'(last_grant), 160'(2));
    check("single_save_c1", 160'(save), 160'(0));
    req = 4'b0000;
    tick();
    check("single_save_c2", 160'(save), 160'(1));
    check("single_data_c2", lcd_data, texts[2]);
    check("single_ack_c2", 160'(ack), 160'(0));
    repeat (5) tick();
    check("single_busy_c7", 160'(busy), 160'(1));
    check("single_save_c7", 160'(save), 160'(0));
    tick();
    check("single_busy_c8", 160'(busy), 160'(0));
    check("single_data_kept", lcd_data, texts[2]);

    // All four requesting continuously.
    pulse_reset();
    req = 4'b1111;
    ng  = 0;
    ns  = 0;
    cyc = 0;
    while (ns < 5 && cyc < 80) begin
      tick();
      cyc++;
      if (ack != 4'b0000 && ng < 8) begin
        grants[ng] = last_grant;
        ng++;
      end
      if (save) begin
        save_cyc[ns] = cyc;
        if (ns < ng) check("rr_save_data", lcd_data, texts[grants[ns][1:0]]);
        ns++;
      end
    end
    req = 4'b0000;
    check("rr_save_count", 160'(ns), 160'(5));
    check("rr_first_save", 160'(save_cyc[0]), 160'(2));
    check("rr_grant0", 160'(grants[0]), 160'(0));
    check("rr_grant1", 160'(grants[1]), 160'(1));
    check("rr_grant2", 160'(grants[2]), 160'(2));
    check("rr_grant3", 160'(grants[3]), 160'(3));
    check("rr_grant4", 160'(grants[4]), 160'(0));
    for (int i = 1; i < 5; i++) begin
      check("rr_spacing", 160'(save_cyc[i] - save_cyc[i-1]), 160'(8));
    end
    wait_idle("rr_idle");

    // Pointer at 1, then requesters 3 and 1 together.
    pulse_reset();
    req = 4'b0010;
    tick();
    check("ptr_setup_grant", 160'(last_grant), 160'(1));
    req = 4'b0000;
    wait_idle("ptr_setup_idle");
    req = 4'b1010;
    ng  = 0;
    cyc = 0;
    while (ng < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (ack != 4'b0000) begin
        grants[ng] = last_grant;
        ng++;
      end
    end
    req = 4'b0000;
    check("pair_grant_count", 160'(ng), 160'(2));
    check("pair_first", 160'(grants[0]), 160'(3));
    check("pair_second", 160'(grants[1]), 160'(1));
    wait_idle("pair_idle");

    // Reset during HOLD.
    pulse_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    check("hold_busy_pre", 160'(busy), 160'(1));
    rst = 1'b1;
    #1;
    check("hold_rst_busy", 160'(busy), 160'(0));
    check("hold_rst_save", 160'(save), 160'(0));
    check("hold_rst_data", lcd_data, blank);
    check("hold_rst_grant", 160'(last_grant), 160'(3));
    tick();
    rst = 1'b0;
    count_saves("hold_rst_no_save", 20);

    // Reset during SAVE.
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    check("save_pre", 160'(save), 160'(1));
    check("save_pre_data", lcd_data, texts[0]);
    rst = 1'b1;
    #1;
    check("save_rst_save", 160'(save), 160'(0));
    check("save_rst_busy", 160'(busy), 160'(0));
    check("save_rst_data", lcd_data, blank);
    tick();
    rst = 1'b0;
    count_saves("save_rst_no_save", 20);

    // Zero hold interval, requester 0 held high.
    rst_z = 1'b0;
    req_z = 4'b0001;
    ns  = 0;
    cyc = 0;
    while (ns < 4 && cyc < 30) begin
      tick();
      cyc++;
      if (save_z) begin
        save_cyc[ns] = cyc;
        ns++;
      end
    end
    req_z = 4'b0000;
    check("zero_save_count", 160'(ns), 160'(4));
    check("zero_first_save", 160'(save_cyc[0]), 160'(2));
    check("zero_data", lcd_data_z, texts[0]);
    for (int i = 1; i < 4; i++) begin
      check("zero_spacing", 160'(save_cyc[i] - save_cyc[i-1]), 160'(3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_line_scheduler.md
# lcd_line_scheduler

Round-robin scheduler that shares the 20-character LCD text path between several independent requesters (menu logic, sensor readout, status messages). Each requester presents one 160-bit line of ASCII text. The scheduler grants one requester at a time, drives the winning line onto `lcd_data`, and issues a one-cycle `save` strobe to the line latch. It then enforces a hold interval so the display sequencer can finish refreshing before the next update. It sits between the requesters and the LCD transfer top level.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; supported range 2..8.
- `HOLD_CYCLES`, 2_000_000 — idle cycles after each `save` (40 ms at 50 MHz `ckht`); 0 is legal.

Ports:
- `ckht` input 1 — system clock; all logic on its rising edge.
- `rst` input 1 — reset; asynchronous, active-high.
- `req` input N_REQ — per-requester update request; level-sensitive.
- `req_text` input N_REQ*160 — requester i's line occupies bits [160*i+159 : 160*i]; char 0 is in bits [159:152].
- `ack` output N_REQ — one-cycle pulse to the granted requester when its text is captured.
- `lcd_data` output 160 — registered line presented to the latch.
- `save` output 1 — one-cycle strobe; `lcd_data` is stable during it.
- `busy` output 1 — high in every state except IDLE.
- `last_grant` output 3 — index of the most recently granted requester.

## Operation
- States:
  - IDLE: wait for any `req` bit.
  - LOAD: capture the winner's text into `lcd_data` and pulse its `ack`.
  - SAVE: `save`=1 for exactly one cycle.
  - HOLD: count down `HOLD_CYCLES`.
- Transitions:
  - IDLE→LOAD when `req` != 0.
  - LOAD→SAVE always.
  - SAVE→HOLD if `HOLD_CYCLES` > 0; SAVE→IDLE otherwise.
  - HOLD→IDLE when the counter reaches 0.
- Arbitration:
  - Round-robin, evaluated in IDLE.
  - Search starts at `last_grant`+1, modulo N_REQ.
  - After reset the pointer is N_REQ-1, so requester 0 has first priority.
- Request handling:
  - The winner is registered on the IDLE→LOAD edge.
  - `req_text` is sampled in LOAD, so the requester must hold its text until `ack`.
  - A request deasserted before it is granted is lost silently.
  - The granted requester must drop `req` after `ack`. If `req` is still high in the next IDLE, it is treated as a new request.
- `req` changes during LOAD, SAVE or HOLD do not affect the current transaction.
- `lcd_data` keeps its last value until the next LOAD; it does not return to blank.
- Hold counter:
  - Width is `$clog2(HOLD_CYCLES+1)`.
  - Loaded with `HOLD_CYCLES`-1 on SAVE→HOLD and decremented in HOLD.
  - No wrap: the exit condition is evaluated at 0.
- Reset mid-transaction:
  - Aborts immediately to IDLE.
  - A pending `ack`/`save` is dropped and is not re-issued after reset.

## Timing
- Reset values:
  - State IDLE.
  - `ack`=0, `save`=0, `busy`=0.
  - `last_grant`=N_REQ-1.
  - `lcd_data`=20×8'h20 (all ASCII spaces).
- Cycle 0: `req` seen in IDLE.
- Cycle 1 (LOAD):
  - `ack[i]`=1.
  - `lcd_data` updates at the end of this cycle.
  - `last_grant`=i.
- Cycle 2 (SAVE): `save`=1 with the new `lcd_data` stable.
- Cycles 3..2+HOLD_CYCLES: HOLD.
- First IDLE cycle: 3+HOLD_CYCLES.
- Minimum spacing between consecutive `save` pulses: 3+HOLD_CYCLES cycles.
- Request-to-save latency: 2 cycles.
- `busy` goes high at cycle 1 and low when IDLE is re-entered.

## Structure
- Shared package `lcd_pkg`:
  - `LCD_CHARS`=20, `LCD_LINE_W`=160, `ASCII_SPACE`=8'h20.
  - Blank-line constant.
  - State enum `lcd_sched_state_t` {IDLE, LOAD, SAVE, HOLD}.
- Sub-module `rr_arbiter`:
  - Parameterized N.
  - Combinational one-hot grant and encoded index from `req` and the pointer.
  - Reused by future LCD/UART sharing blocks.
- Top level holds the FSM, hold counter, `lcd_data` register and text mux.

## Test plan
Benches use `HOLD_CYCLES`=5.
- Reset release with no `req`:
  - `lcd_data`=all 8'h20, `busy`=0, `save` never asserted for 50 cycles.
- Single request:
  - `req`=4'b0100, text "TEMP 25C" padded.
  - `ack`=4'b0100 at cycle 1, `save` at cycle 2 with matching `lcd_data`.
  - `busy` low at cycle 8.
- All four `req` held high continuously:
  - Grants 0,1,2,3,0.
  - `save` pulses exactly 8 cycles apart.
- Simultaneous `req`=4'b1010 after `last_grant`=1: requester 3 granted first, then 1.
- `rst` asserted during HOLD and during SAVE:
  - Outputs return to reset values asynchronously; no extra `save`.
  - `lcd_data` is blank.
- `HOLD_CYCLES`=0 build with continuous `req[0]`: `save` every 3 cycles.
